// File: rtl/liang_pkg.sv
// Shared types and defaults for the liang core front end.
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2
    } ifu_state_e;

    localparam pc_t   RESET_PC_DEFAULT = 32'h8000_0000;
    // addi x0,x0,0 -- substituted for the word of a faulting fetch
    localparam inst_t NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one imem read at a time
// and presents the result to decode through a one-entry registered buffer.
module ifu_fetch
    import liang_pkg::pc_t, liang_pkg::inst_t, liang_pkg::ifu_state_e;
#(
    parameter pc_t   RESET_PC = liang_pkg::RESET_PC_DEFAULT,
    parameter inst_t NOP_INST = liang_pkg::NOP_INST
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  redirect_valid_i,
    input  pc_t   redirect_pc_i,
    output logic  imem_req_valid_o,
    input  logic  imem_req_ready_i,
    output pc_t   imem_req_addr_o,
    input  logic  imem_rsp_valid_i,
    output logic  imem_rsp_ready_o,
    input  inst_t imem_rsp_data_i,
    input  logic  imem_rsp_err_i,
    output logic  if_valid_o,
    input  logic  if_ready_i,
    output pc_t   pc_o,
    output inst_t inst_o,
    output logic  fetch_err_o
);

    ifu_state_e state_reg, state_next;
    pc_t        pc_reg, pc_next;
    logic       drop_reg, drop_next;
    logic       valid_reg, valid_next;
    pc_t        out_pc_reg, out_pc_next;
    inst_t      inst_reg, inst_next;
    logic       err_reg, err_next;

    logic misaligned;
    logic req_fire;

    assign misaligned       = |pc_reg[1:0];
    assign imem_req_valid_o = (state_reg == liang_pkg::REQ) && !misaligned;
    assign imem_req_addr_o  = pc_reg;
    assign imem_rsp_ready_o = (state_reg == liang_pkg::WAIT_RSP);
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign if_valid_o  = valid_reg;
    assign pc_o        = out_pc_reg;
    assign inst_o      = inst_reg;
    assign fetch_err_o = err_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= liang_pkg::REQ;
            pc_reg     <= RESET_PC;
            drop_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            out_pc_reg <= '0;
            inst_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            drop_reg   <= drop_next;
            valid_reg  <= valid_next;
            out_pc_reg <= out_pc_next;
            inst_reg   <= inst_next;
            err_reg    <= err_next;
        end
    end

    // Redirect is evaluated first in every state so it overrides any other event.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        drop_next   = drop_reg;
        valid_next  = valid_reg;
        out_pc_next = out_pc_reg;
        inst_next   = inst_reg;
        err_next    = err_reg;

        case (state_reg)
            liang_pkg::REQ: begin
                if (redirect_valid_i) begin
                    pc_next = redirect_pc_i;
                    if (req_fire) begin
                        // The old-path request is already on the bus; its response must be eaten.
                        state_next = liang_pkg::WAIT_RSP;
                        drop_next  = 1'b1;
                    end
                end else if (misaligned) begin
                    out_pc_next = pc_reg;
                    inst_next   = NOP_INST;
                    err_next    = 1'b1;
                    valid_next  = 1'b1;
                    state_next  = liang_pkg::HOLD;
                end else if (req_fire) begin
                    state_next = liang_pkg::WAIT_RSP;
                end
            end

            liang_pkg::WAIT_RSP: begin
                if (redirect_valid_i) begin
                    pc_next = redirect_pc_i;
                    if (imem_rsp_valid_i) begin
                        state_next = liang_pkg::REQ;
                        drop_next  = 1'b0;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = liang_pkg::REQ;
                    end else begin
                        out_pc_next = pc_reg;
                        inst_next   = imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
                        err_next    = imem_rsp_err_i;
                        valid_next  = 1'b1;
                        pc_next     = pc_reg + 32'd4;
                        state_next  = liang_pkg::HOLD;
                    end
                end
            end

            liang_pkg::HOLD: begin
                if (redirect_valid_i) begin
                    valid_next = 1'b0;
                    pc_next    = redirect_pc_i;
                    state_next = liang_pkg::REQ;
                end else if (if_ready_i) begin
                    valid_next = 1'b0;
                    state_next = liang_pkg::REQ;
                end
            end

            default: begin
                state_next = liang_pkg::REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected decode outputs are queued when the
// memory response is driven and compared when the decoder handshake occurs.
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic        imem_rsp_ready_o;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fetch_err_o;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    ifu_fetch #(
        .RESET_PC (32'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_ready_o (imem_rsp_ready_o),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .fetch_err_o      (fetch_err_o)
    );

    always #5 clk = ~clk;

    // Decoder-side scoreboard: every real handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && if_valid_o && if_ready_i && !redirect_valid_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h err=%b, required no handshake", pc_o, inst_o, fetch_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({pc_o, inst_o, fetch_err_o} !== e) begin
                    errors++;
                    $display("FAIL sb_handshake: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                             pc_o, inst_o, fetch_err_o, e.pc, e.inst, e.err);
                end else begin
                    $display("handshake pc=%h inst=%h err=%b", pc_o, inst_o, fetch_err_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call from just after a rising edge; returns at the negedge the request is seen.
    task automatic wait_req(output logic [31:0] addr, output bit ok);
        ok   = 1'b0;
        addr = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (imem_req_valid_o) begin
                addr = imem_req_addr_o;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    // Call at the negedge where a request is visible with ready high.
    task automatic respond(input logic [31:0] data, input logic err, input int delay);
        tick();
        repeat (delay) tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = data;
        imem_rsp_err_i   = err;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        if_ready_i       = 1'b1;
        #3;
        checks++;
        if ({if_valid_o, pc_o, inst_o, fetch_err_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pc=%h inst=%h err=%b, required all zero", if_valid_o, pc_o, inst_o, fetch_err_o);
        end
        checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000 || imem_rsp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_imem: got req_v=%b addr=%h rsp_rdy=%b, required 1 80000000 0", imem_req_valid_o, imem_req_addr_o, imem_rsp_ready_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] a;
        bit ok;
        if_ready_i = 1'b1;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0000) begin
            errors++;
            $display("FAIL basic_req_addr: got %h (seen=%0d), required 80000000", a, ok);
        end
        exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h0010_0093, err: 1'b0});
        respond(32'h0010_0093, 1'b0, 1);
        @(negedge clk);
        checks++;
        if (if_valid_o !== 1'b1 || pc_o !== 32'h8000_0000 || inst_o !== 32'h0010_0093) begin
            errors++;
            $display("FAIL basic_present: got v=%b pc=%h inst=%h, required 1 80000000 00100093", if_valid_o, pc_o, inst_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        bit ok;
        if_ready_i = 1'b0;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0004) begin
            errors++;
            $display("FAIL bp_req_addr: got %h (seen=%0d), required 80000004", a, ok);
        end
        exp_q.push_back('{pc: 32'h8000_0004, inst: 32'h0020_0113, err: 1'b0});
        respond(32'h0020_0113, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (if_valid_o !== 1'b1 || pc_o !== 32'h8000_0004 || inst_o !== 32'h0020_0113 || imem_req_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: cycle %0d got v=%b pc=%h inst=%h req_v=%b, required 1 80000004 00200113 0",
                         k, if_valid_o, pc_o, inst_o, imem_req_valid_o);
            end
            tick();
        end
        if_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_rsp_error();
        logic [31:0] a;
        bit ok;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0008) begin
            errors++;
            $display("FAIL err_req_addr: got %h (seen=%0d), required 80000008", a, ok);
        end
        exp_q.push_back('{pc: 32'h8000_0008, inst: NOP, err: 1'b1});
        respond(32'hFFFF_FFFF, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (fetch_err_o !== 1'b1 || inst_o !== NOP || pc_o !== 32'h8000_0008) begin
            errors++;
            $display("FAIL err_present: got err=%b inst=%h pc=%h, required 1 00000013 80000008", fetch_err_o, inst_o, pc_o);
        end
        tick();
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a;
        bit ok;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_000C) begin
            errors++;
            $display("FAIL rdw_req_addr: got %h (seen=%0d), required 8000000c", a, ok);
        end
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0100;
        tick();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (imem_rsp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rdw_rsp_ready: got %b, required 1", imem_rsp_ready_o);
        end
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin
                errors++;
                $display("FAIL rdw_squash: cycle %0d got v=%b req_v=%b addr=%h, required 0 1 80000100",
                         k, if_valid_o, imem_req_valid_o, imem_req_addr_o);
            end
            tick();
        end
        imem_req_ready_i = 1'b1;
    endtask

    task automatic test_redirect_hold();
        logic [31:0] a;
        bit ok;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rdh_req_addr: got %h (seen=%0d), required 80000100", a, ok);
        end
        respond(32'h1111_1111, 1'b0, 0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0200;
        @(negedge clk);
        checks++;
        if (if_valid_o !== 1'b1 || pc_o !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rdh_before: got v=%b pc=%h, required 1 80000100", if_valid_o, pc_o);
        end
        tick();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0200) begin
            errors++;
            $display("FAIL rdh_after: got v=%b req_v=%b addr=%h, required 0 1 80000200", if_valid_o, imem_req_valid_o, imem_req_addr_o);
        end
        tick();
    endtask

    task automatic test_misaligned();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0102;
        if_ready_i       = 1'b0;
        tick();
        redirect_valid_i = 1'b0;
        exp_q.push_back('{pc: 32'h8000_0102, inst: NOP, err: 1'b1});
        @(negedge clk);
        checks++;
        if (imem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_no_req: got req_v=%b, required 0", imem_req_valid_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_valid_o !== 1'b1 || fetch_err_o !== 1'b1 || pc_o !== 32'h8000_0102 || inst_o !== NOP || imem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_present: got v=%b err=%b pc=%h inst=%h req_v=%b, required 1 1 80000102 00000013 0",
                     if_valid_o, fetch_err_o, pc_o, inst_o, imem_req_valid_o);
        end
        tick();
        if_ready_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0300;
        tick();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0300) begin
            errors++;
            $display("FAIL wrap_req_addr: got %h (seen=%0d), required 80000300", a, ok);
        end
        exp_q.push_back('{pc: 32'h8000_0300, inst: 32'h0030_0193, err: 1'b0});
        respond(32'h0030_0193, 1'b0, 2);
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        @(negedge clk);
        checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0304) begin
            errors++;
            $display("FAIL wrap_req_redirect: got req_v=%b addr=%h, required 1 80000304", imem_req_valid_o, imem_req_addr_o);
        end
        tick();
        redirect_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rsp_ready_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drop_wait: got rsp_rdy=%b req_v=%b, required 1 0", imem_rsp_ready_o, imem_req_valid_o);
        end
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0BAD_0BAD;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC || if_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_after_drop: got addr=%h (seen=%0d) v=%b, required fffffffc 0", a, ok, if_valid_o);
        end
        exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0040_0213, err: 1'b0});
        respond(32'h0040_0213, 1'b0, 0);
        tick();
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_next_addr: got %h (seen=%0d), required 00000000", a, ok);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] a;
        bit ok;
        tick();
        @(negedge clk);
        checks++;
        if (imem_rsp_ready_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL ar_pre: got rsp_rdy=%b pc=%h, required 1 fffffffc", imem_rsp_ready_o, pc_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({if_valid_o, pc_o, inst_o, fetch_err_o} !== 66'd0 || imem_rsp_ready_o !== 1'b0 || imem_req_addr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ar_immediate: got v=%b pc=%h inst=%h err=%b rsp_rdy=%b addr=%h, required 0 0 0 0 0 80000000",
                     if_valid_o, pc_o, inst_o, fetch_err_o, imem_rsp_ready_o, imem_req_addr_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_req(a, ok);
        checks++;
        if (!ok || a !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ar_req_addr: got %h (seen=%0d), required 80000000", a, ok);
        end
        exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h0050_0293, err: 1'b0});
        respond(32'h0050_0293, 1'b0, 1);
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_rsp_error();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
